// File: rtl/lut_neuron_pkg.sv
// Shared defaults and state encoding for the runtime-programmable LogicNet neuron.
package lut_neuron_pkg;

   localparam int unsigned DEF_IN_BITS  = 4;
   localparam int unsigned DEF_OUT_BITS = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } state_t;

endpackage

// File: rtl/lut_neuron_table.sv
// ENTRIES x OUT_BITS truth-table storage: one write port, combinational read, async clear.
module lut_neuron_table
   import lut_neuron_pkg::*;
#(
   parameter int unsigned IN_BITS  = DEF_IN_BITS,
   parameter int unsigned OUT_BITS = DEF_OUT_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [IN_BITS-1:0]  waddr,
   input  logic [OUT_BITS-1:0] wdata,
   input  logic [IN_BITS-1:0]  raddr,
   output logic [OUT_BITS-1:0] rdata
);

   localparam int unsigned ENTRIES = 2**IN_BITS;

   logic [OUT_BITS-1:0] mem [ENTRIES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_prog.sv
// Programmable LogicNet neuron: serial table load over cfg stream, then registered lookups.
module lut_neuron_prog
   import lut_neuron_pkg::*;
#(
   parameter int unsigned IN_BITS  = DEF_IN_BITS,
   parameter int unsigned OUT_BITS = DEF_OUT_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_start,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [OUT_BITS-1:0] cfg_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_BITS-1:0]  in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_BITS-1:0] out_data,
   output logic                loaded,
   output logic                busy
);

   localparam int unsigned    ENTRIES = 2**IN_BITS;
   localparam logic [IN_BITS:0] LAST  = (IN_BITS+1)'(ENTRIES - 1);

   state_t              state, state_nx;
   logic [IN_BITS:0]    cnt, cnt_nx;
   logic                loaded_nx;
   logic                we;
   logic                in_acc;
   logic [OUT_BITS-1:0] rdata;

   lut_neuron_table #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
   ) u_table (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (cnt[IN_BITS-1:0]),
      .wdata (cfg_data),
      .raddr (in_data),
      .rdata (rdata)
   );

   // cfg_start masks cfg_ready so a restart never half-accepts a beat
   assign cfg_ready = (state == LOAD) && !cfg_start;
   assign in_ready  = (state == RUN) && (!out_valid || out_ready);
   assign busy      = (state == LOAD);
   assign in_acc    = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= EMPTY;
         cnt    <= '0;
         loaded <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         loaded <= loaded_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      loaded_nx = loaded;
      we        = 1'b0;
      case (state)
         EMPTY: begin
            if (cfg_start) begin
               state_nx = LOAD;
               cnt_nx   = '0;
            end
         end
         LOAD: begin
            if (cfg_start) begin
               cnt_nx = '0;
            end else if (cfg_valid) begin
               we     = 1'b1;
               cnt_nx = cnt + 1'b1;
               if (cnt == LAST) begin
                  state_nx  = RUN;
                  loaded_nx = 1'b1;
               end
            end
         end
         RUN: begin
            if (cfg_start) begin
               state_nx  = LOAD;
               cnt_nx    = '0;
               loaded_nx = 1'b0;
            end
         end
         default: state_nx = EMPTY;
      endcase
   end

   // Result register is independent of the FSM so a pending result survives a reload
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_acc) begin
         out_valid <= 1'b1;
         out_data  <= rdata;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Scoreboard bench for lut_neuron_prog: directed loads and lookups, monitor-side result checking.
module tb_lut_neuron_prog;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_start = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [1:0] cfg_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [1:0] out_data;
   logic       loaded;
   logic       busy;

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned cyc    = 0;
   int          sb[$];

   logic [1:0] ta [16];
   logic [1:0] tb2 [16];
   logic [1:0] tones [16];
   logic [1:0] tc [16];
   logic [1:0] td [16];

   lut_neuron_prog #(
      .IN_BITS  (4),
      .OUT_BITS (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_data  (cfg_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .loaded    (loaded),
      .busy      (busy)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Monitor: inputs settle at negedge, handshakes are judged at negedge+2
   always @(negedge clk) begin
      int e;
      #2;
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL spurious_out: out_valid=1 data=%0d with nothing expected (t=%0t)", out_data, $time);
         end else if (out_ready) begin
            e = sb.pop_front();
            chk("out_data", int'(out_data), e);
         end
      end
   end

   task automatic lookup(input int code, input int exp);
      int g = 0;
      in_valid = 1'b1;
      in_data  = 4'(code);
      #1;
      while (!in_ready && g < 50) begin
         @(negedge clk); #1; g++;
      end
      if (!in_ready) chk("in_ready_timeout", int'(in_ready), 1);
      else sb.push_back(exp);
      @(negedge clk);
   endtask

   task automatic sweep(input logic [1:0] t [16]);
      out_ready = 1'b1;
      for (int c = 0; c < 16; c++) lookup(c, int'(t[c]));
      in_valid = 1'b0;
   endtask

   task automatic start_pulse(input logic v, input logic [1:0] d);
      cfg_start = 1'b1;
      cfg_valid = v;
      cfg_data  = d;
      #1;
      chk("cfg_ready_on_start", int'(cfg_ready), 0);
      @(negedge clk);
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
   endtask

   task automatic send_beats(input logic [1:0] t [16], input int n);
      for (int k = 0; k < n; k++) begin
         int g = 0;
         cfg_valid = 1'b1;
         cfg_data  = t[k];
         #1;
         while (!cfg_ready && g < 50) begin
            @(negedge clk); #1; g++;
         end
         if (!cfg_ready) chk("cfg_ready_timeout", int'(cfg_ready), 1);
         @(negedge clk);
      end
      cfg_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (sb.size() != 0 && g < 20) begin
         @(negedge clk); g++;
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      for (int k = 0; k < 16; k++) begin
         ta[k]    = 2'd0;
         tb2[k]   = 2'd2;
         tones[k] = 2'd1;
         tc[k]    = 2'((k * 3) % 4);
         td[k]    = 2'(3 - (k % 4));
      end
      ta[2] = 2'd3; ta[3] = 2'd3; ta[6] = 2'd1;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data",  int'(out_data), 0);
      chk("rst_loaded",    int'(loaded), 0);
      chk("rst_busy",      int'(busy), 0);
      chk("rst_cfg_ready", int'(cfg_ready), 0);
      chk("rst_in_ready",  int'(in_ready), 0);
      @(negedge clk);
      rst = 1'b0;

      // EMPTY ignores lookups and config beats without cfg_start
      in_valid = 1'b1; in_data = 4'd5; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1; chk("empty_in_ready", int'(in_ready), 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      cfg_valid = 1'b1; cfg_data = 2'd3;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("empty_cfg_ready", int'(cfg_ready), 0);
         chk("empty_busy", int'(busy), 0);
         @(negedge clk);
      end
      cfg_valid = 1'b0;

      // Table A, then a lookup with explicit 1-cycle latency check
      start_pulse(1'b0, 2'd0);
      #1; chk("load_busy", int'(busy), 1);
      @(negedge clk);
      send_beats(ta, 16);
      #1;
      chk("loaded_after_load", int'(loaded), 1);
      chk("busy_after_load", int'(busy), 0);
      chk("in_ready_after_load", int'(in_ready), 1);
      @(negedge clk);
      out_ready = 1'b1;
      lookup(6, 1);
      in_valid = 1'b0;
      #1;
      chk("latency_out_valid", int'(out_valid), 1);
      chk("latency_out_data", int'(out_data), 1);
      @(negedge clk);
      drain();

      // Sweep with a 5-cycle stall after code 2
      lookup(0, 0); lookup(1, 0); lookup(2, 3);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 4'd3;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_out_valid", int'(out_valid), 1);
         chk("stall_out_data", int'(out_data), 3);
         chk("stall_in_ready", int'(in_ready), 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", int'(in_ready), 1);
      sb.push_back(3);
      @(negedge clk);
      t0 = int'(cyc);
      for (int c = 4; c < 16; c++) lookup(c, int'(ta[c]));
      in_valid = 1'b0;
      chk("throughput_cycles", int'(cyc) - t0, 12);
      drain();

      // Reload from RUN while a result is pending
      out_ready = 1'b0;
      lookup(6, 1);
      in_valid = 1'b0;
      start_pulse(1'b0, 2'd0);
      #1;
      chk("reload_loaded_cleared", int'(loaded), 0);
      chk("reload_busy", int'(busy), 1);
      @(negedge clk);
      send_beats(tc, 16);
      #1;
      chk("pending_out_valid", int'(out_valid), 1);
      chk("pending_out_data", int'(out_data), 1);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      sweep(tc);
      drain();

      // Restart mid-load: 7 beats of 2, restart with a beat offered, then 16 beats of 1
      start_pulse(1'b0, 2'd0);
      send_beats(tb2, 7);
      start_pulse(1'b1, 2'd3);
      send_beats(tones, 16);
      sweep(tones);
      drain();

      // Async reset on beat 9, then a fresh full load
      start_pulse(1'b0, 2'd0);
      send_beats(td, 9);
      rst = 1'b1;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_loaded", int'(loaded), 0);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_cfg_ready", int'(cfg_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1; in_data = 4'd1;
      #1; chk("midrst_in_ready", int'(in_ready), 0);
      @(negedge clk);
      in_valid = 1'b0;
      start_pulse(1'b0, 2'd0);
      send_beats(td, 16);
      sweep(td);
      drain();

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
